// File: rtl/apb_i2c_fifo.sv
// First-word-fall-through FIFO between the APB bridge and the I2C core.
// Provides occupancy, an almost-full threshold and sticky overflow/underflow flags.
module apb_i2c_fifo #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              WR_EN,
    input  logic [DWIDTH-1:0] WR_DATA,
    input  logic              RD_EN,
    output logic [DWIDTH-1:0] RD_DATA,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ALMOST_FULL,
    output logic [AWIDTH:0]   LEVEL,
    input  logic              CLR_ERR,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              ERROR
);
    localparam int              DEPTH     = 1 << AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE   = 1;
    localparam logic [AWIDTH:0] LVL_FULL  = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] LVL_AF    = AF_LEVEL[AWIDTH:0];

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]   r_wptr;
    logic [AWIDTH:0]   r_rptr;
    logic              r_ovf;
    logic              r_udf;

    logic [AWIDTH:0]   w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Extra wrap bit makes the modular difference span 0..DEPTH.
    assign w_level   = r_wptr - r_rptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == LVL_FULL);
    assign w_pop     = RD_EN && !w_empty;
    assign w_push    = WR_EN && (!w_full || w_pop);
    assign w_ovf_set = WR_EN && !w_push;
    assign w_udf_set = RD_EN && w_empty;

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wptr[AWIDTH-1:0]] <= WR_DATA;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            // A fresh error in the clearing cycle takes priority over the clear.
            r_ovf <= w_ovf_set || (r_ovf && !CLR_ERR);
            r_udf <= w_udf_set || (r_udf && !CLR_ERR);
        end
    end

    assign RD_DATA     = w_empty ? '0 : r_mem[r_rptr[AWIDTH-1:0]];
    assign EMPTY       = w_empty;
    assign FULL        = w_full;
    assign ALMOST_FULL = (w_level >= LVL_AF);
    assign LEVEL       = w_level;
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_udf;
    assign ERROR       = r_ovf || r_udf;
endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Directed bench for apb_i2c_fifo: a queue model checked every cycle, plus literal pins.
module tb_apb_i2c_fifo;
    logic        PCLK;
    logic        PRESETn;
    logic        WR_EN;
    logic [31:0] WR_DATA;
    logic        RD_EN;
    logic [31:0] RD_DATA;
    logic        EMPTY;
    logic        FULL;
    logic        ALMOST_FULL;
    logic [4:0]  LEVEL;
    logic        CLR_ERR;
    logic        OVERFLOW;
    logic        UNDERFLOW;
    logic        ERROR;

    apb_i2c_fifo #(.DWIDTH(32), .AWIDTH(4), .AF_LEVEL(12)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .LEVEL(LEVEL), .CLR_ERR(CLR_ERR),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ERROR(ERROR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the queue model.
    always @(negedge PCLK) begin
        if (chk_en) begin
            int lvl;
            lvl = m_q.size();
            chk("cyc_level", 32'(LEVEL), 32'(lvl));
            chk("cyc_empty", 32'(EMPTY), 32'(lvl == 0));
            chk("cyc_full", 32'(FULL), 32'(lvl == 16));
            chk("cyc_afull", 32'(ALMOST_FULL), 32'(lvl >= 12));
            chk("cyc_rdata", RD_DATA, (lvl == 0) ? 32'h0 : m_q[0]);
            chk("cyc_ovf", 32'(OVERFLOW), 32'(m_ovf));
            chk("cyc_udf", 32'(UNDERFLOW), 32'(m_udf));
            chk("cyc_err", 32'(ERROR), 32'(m_ovf || m_udf));
        end
    end

    // One clock of stimulus; the model advances by the FIFO's rules at the edge.
    task automatic cyc(input bit wr, input logic [31:0] d, input bit rd, input bit clr);
        bit pop, push, ovf_set, udf_set;
        WR_EN = wr; WR_DATA = d; RD_EN = rd; CLR_ERR = clr;
        @(posedge PCLK);
        pop     = rd && (m_q.size() != 0);
        push    = wr && ((m_q.size() < 16) || pop);
        ovf_set = wr && !push;
        udf_set = rd && (m_q.size() == 0);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(d);
        m_ovf = ovf_set || (m_ovf && !clr);
        m_udf = udf_set || (m_udf && !clr);
        $display("cyc wr=%0b d=%h rd=%0b clr=%0b -> level=%0d rd_data=%h", wr, d, rd, clr, LEVEL, RD_DATA);
        @(negedge PCLK);
        #1;
        WR_EN = 1'b0; RD_EN = 1'b0; CLR_ERR = 1'b0;
    endtask

    logic [31:0] obs[$];
    logic [31:0] exp_w;

    initial begin
        PRESETn = 1'b0; WR_EN = 1'b0; WR_DATA = '0; RD_EN = 1'b0; CLR_ERR = 1'b0;
        #1;
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_afull", 32'(ALMOST_FULL), 32'd0);
        chk("rst_rdata", RD_DATA, 32'h0);
        chk("rst_err", 32'(ERROR), 32'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk_en = 1'b1;

        // Basic push then pop
        cyc(1, 32'h11111111, 0, 0);
        chk("p1_level", 32'(LEVEL), 32'd1);
        chk("p1_rdata", RD_DATA, 32'h11111111);
        cyc(1, 32'h22222222, 0, 0);
        chk("p2_level", 32'(LEVEL), 32'd2);
        cyc(1, 32'h33333333, 0, 0);
        chk("p3_level", 32'(LEVEL), 32'd3);
        cyc(0, 0, 1, 0);
        chk("pop1_rdata", RD_DATA, 32'h22222222);
        cyc(0, 0, 1, 0);
        chk("pop2_rdata", RD_DATA, 32'h33333333);
        cyc(0, 0, 1, 0);
        chk("pop3_rdata", RD_DATA, 32'h0);
        chk("pop3_empty", 32'(EMPTY), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            cyc(1, 32'(i), 0, 0);
            chk("fill_level", 32'(LEVEL), 32'(i + 1));
            chk("fill_afull", 32'(ALMOST_FULL), 32'(i >= 11));
            chk("fill_full", 32'(FULL), 32'(i == 15));
        end
        cyc(1, 32'hDEAD, 0, 0);
        chk("ovf_flag", 32'(OVERFLOW), 32'd1);
        chk("ovf_error", 32'(ERROR), 32'd1);
        chk("ovf_level", 32'(LEVEL), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", RD_DATA, 32'(i));
            cyc(0, 0, 1, 0);
        end
        chk("drain_empty", 32'(EMPTY), 32'd1);
        cyc(0, 0, 0, 1);
        chk("ovf_clr", 32'(OVERFLOW), 32'd0);

        // Simultaneous push/pop while full
        for (int i = 0; i < 16; i++) cyc(1, 32'(i), 0, 0);
        cyc(1, 32'hAAAA, 1, 0);
        chk("fpp_level", 32'(LEVEL), 32'd16);
        chk("fpp_head", RD_DATA, 32'd1);
        chk("fpp_noovf", 32'(OVERFLOW), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            chk("fpp_drain", RD_DATA, (i == 16) ? 32'hAAAA : 32'(i));
            cyc(0, 0, 1, 0);
        end

        // Underflow and clear priority
        cyc(0, 0, 1, 0);
        chk("udf_flag", 32'(UNDERFLOW), 32'd1);
        chk("udf_level", 32'(LEVEL), 32'd0);
        cyc(0, 0, 0, 1);
        chk("udf_clr", 32'(UNDERFLOW), 32'd0);
        cyc(0, 0, 1, 1);
        chk("udf_setwins", 32'(UNDERFLOW), 32'd1);
        cyc(0, 0, 0, 1);

        // Push and pop together while empty
        cyc(1, 32'h55, 1, 0);
        chk("epp_level", 32'(LEVEL), 32'd1);
        chk("epp_udf", 32'(UNDERFLOW), 32'd1);
        chk("epp_rdata", RD_DATA, 32'h55);
        cyc(0, 0, 1, 1);

        // Prefill 5, then stream 40 with push and pop each cycle
        for (int k = 0; k < 5; k++) cyc(1, 32'h1000 + 32'(k), 0, 0);
        for (int k = 0; k < 40; k++) begin
            obs.push_back(RD_DATA);
            cyc(1, 32'h2000 + 32'(k), 1, 0);
            chk("stream_level", 32'(LEVEL), 32'd5);
        end
        for (int k = 0; k < 40; k++) begin
            exp_w = (k < 5) ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k - 5);
            chk("stream_order", obs[k], exp_w);
        end

        // Asynchronous reset mid-stream, away from any edge
        #2;
        PRESETn = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        chk("arst_empty", 32'(EMPTY), 32'd1);
        chk("arst_level", 32'(LEVEL), 32'd0);
        chk("arst_rdata", RD_DATA, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        cyc(1, 32'h77, 0, 0);
        chk("post_rst_rdata", RD_DATA, 32'h77);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
